// File: rtl/multi_pipe_param_if.sv
// Operand/result handshake bundle for multi_pipe_param.
//   master: producer/consumer side (drives operands, out_ready and flush)
//   slave : multiplier side (drives in_ready, out_valid, mul_out and busy)
// Signals:
//   flush              synchronous kill of every in-flight operation
//   in_valid/in_ready  operand handshake; in_signed selects two's complement
//   mul_a, mul_b       WIDTH-bit operands
//   out_valid/out_ready result handshake; mul_out is the 2*WIDTH-bit product
//   busy               some stage holds a valid operation
interface multi_pipe_param_if #(
  parameter int WIDTH = 8
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] mul_out;
  logic               busy;

  modport master (
    output flush, in_valid, in_signed, mul_a, mul_b, out_ready,
    input  in_ready, out_valid, mul_out, busy
  );

  modport slave (
    input  flush, in_valid, in_signed, mul_a, mul_b, out_ready,
    output in_ready, out_valid, mul_out, busy
  );
endinterface

// File: rtl/multi_pipe_param.sv
// Pipelined shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or
// unsigned per operation, with valid/ready backpressure and synchronous flush.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  multi_pipe_param_if.slave (operands, result, flush, busy)
// Pipeline: S0 holds operand magnitudes and the result sign, S1..S(LVL-1)
// are adder-tree levels, S(LVL) is the final sum/negate and output register.
// Latency is LVL+1 cycles. All stages move together when the output slot is
// free or being consumed; otherwise everything holds.
module multi_pipe_param #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  multi_pipe_param_if.slave bus
);
  localparam int LVL = $clog2(WIDTH);
  localparam int W2  = 2 * WIDTH;

  logic             advance_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;

  logic             v0_r;
  logic             neg0_r;
  logic [WIDTH-1:0] a_mag_r;
  logic [WIDTH-1:0] b_mag_r;

  logic [W2-1:0]    pp_s   [WIDTH];
  // Level k uses entries 0 .. (WIDTH>>k)-1 of row k.
  logic [W2-1:0]    tree_r [1:LVL-1][WIDTH/2];
  logic [LVL-1:1]   v_tree_r;
  logic [LVL-1:1]   neg_tree_r;
  logic [W2-1:0]    fin_sum_s;

  logic             out_valid_r;
  logic [W2-1:0]    mul_out_r;

  assign advance_s = ~out_valid_r | bus.out_ready;

  // Operand magnitudes; -2^(WIDTH-1) negates to itself, which is its
  // correct unsigned magnitude.
  assign a_neg_s = bus.in_signed & bus.mul_a[WIDTH-1];
  assign b_neg_s = bus.in_signed & bus.mul_b[WIDTH-1];
  assign a_mag_s = a_neg_s ? ({WIDTH{1'b0}} - bus.mul_a) : bus.mul_a;
  assign b_mag_s = b_neg_s ? ({WIDTH{1'b0}} - bus.mul_b) : bus.mul_b;

  // Partial products from the S0 magnitudes.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp_s[i] = b_mag_r[i] ? ({{WIDTH{1'b0}}, a_mag_r} << i) : {W2{1'b0}};
    end
  end

  assign fin_sum_s = tree_r[LVL-1][0] + tree_r[LVL-1][1];

  // Pipeline registers: reset, flush (clears valids, zeroes output), advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_r        <= 1'b0;
      neg0_r      <= 1'b0;
      a_mag_r     <= {WIDTH{1'b0}};
      b_mag_r     <= {WIDTH{1'b0}};
      v_tree_r    <= '0;
      neg_tree_r  <= '0;
      out_valid_r <= 1'b0;
      mul_out_r   <= {W2{1'b0}};
      for (int k = 1; k < LVL; k++) begin
        for (int j = 0; j < WIDTH / 2; j++) begin
          tree_r[k][j] <= {W2{1'b0}};
        end
      end
    end else if (bus.flush) begin
      v0_r        <= 1'b0;
      v_tree_r    <= '0;
      out_valid_r <= 1'b0;
      mul_out_r   <= {W2{1'b0}};
    end else if (advance_s) begin
      v0_r    <= bus.in_valid;
      neg0_r  <= a_neg_s ^ b_neg_s;
      a_mag_r <= a_mag_s;
      b_mag_r <= b_mag_s;

      v_tree_r[1]   <= v0_r;
      neg_tree_r[1] <= neg0_r;
      for (int j = 0; j < WIDTH / 2; j++) begin
        tree_r[1][j] <= pp_s[2*j] + pp_s[2*j+1];
      end
      for (int k = 2; k < LVL; k++) begin
        v_tree_r[k]   <= v_tree_r[k-1];
        neg_tree_r[k] <= neg_tree_r[k-1];
        for (int j = 0; j < (WIDTH >> k); j++) begin
          tree_r[k][j] <= tree_r[k-1][2*j] + tree_r[k-1][2*j+1];
        end
      end

      // Bubbles leave a zero on mul_out.
      out_valid_r <= v_tree_r[LVL-1];
      if (v_tree_r[LVL-1]) begin
        mul_out_r <= neg_tree_r[LVL-1] ? ({W2{1'b0}} - fin_sum_s) : fin_sum_s;
      end else begin
        mul_out_r <= {W2{1'b0}};
      end
    end
  end

  assign bus.in_ready  = advance_s;
  assign bus.out_valid = out_valid_r;
  assign bus.mul_out   = mul_out_r;
  assign bus.busy      = v0_r | (|v_tree_r) | out_valid_r;
endmodule
